twodigit_entry: RTL and testbench
=================================

// Module: twodigit_entry
// PURPOSE
//  Decimal-to-binary entry block for the cpu 2021 board: the input-side mirror of the
//  binary-to-two-digit display path. Accepts BCD digits one at a time (keypad/switch
//  strobes), holds up to two digits for echo on the seven-segment displays, and on
//  'enter' commits tens*10+ones as a binary address with a one-cycle valid pulse.
//  It sits between the front-panel input logic and the CPU address/load logic.
// PARAMETERS
//  ADDR_W     6                Committed address width; legal range 4..7.
//  MAX_VALUE  (1<<ADDR_W)-1    Largest committable value. Must not exceed 99.
// PORTS
//  clock        in   1       System clock; all state updates on the rising edge.
//  reset        in   1       Asynchronous, active-high reset.
//  digit_in     in   4       BCD digit. Sampled only when digit_valid=1.
//  digit_valid  in   1       Single-cycle strobe: append digit_in.
//  enter        in   1       Single-cycle strobe: commit the held digits.
//  clear        in   1       Single-cycle strobe: discard the held digits.
//  address      out  ADDR_W  Last committed value. Registered.
//  addr_valid   out  1       One-cycle pulse when address is updated.
//  error        out  1       One-cycle pulse on any rejected event.
//  tens_bcd     out  4       Held tens digit, for display echo.
//  ones_bcd     out  4       Held ones digit, for display echo.
//  count        out  2       Number of digits held: 0, 1 or 2.
// BEHAVIOUR
//  Reset (async): state=EMPTY; address=0, addr_valid=0, error=0, tens/ones=0, count=0.
//  FSM states: EMPTY (count 0), ONE (count 1), TWO (count 2). count is the encoded state.
//  Priority within a cycle: clear > enter > digit_valid.
//  - clear: go to EMPTY, tens=ones=0. No pulse. Any enter/digit in the same cycle is
//    dropped silently.
//  - digit_valid with digit_in>9: digit ignored, state unchanged, error pulse.
//  - EMPTY + digit d: ones=d, tens=0 -> ONE.
//  - ONE + digit d: tens=ones, ones=d -> TWO (the left-shift entry order).
//  - TWO + digit: full; digit ignored, digits unchanged, error pulse.
//  - enter in EMPTY: error pulse, address unchanged, stay EMPTY.
//  - enter in ONE/TWO: value=tens*10+ones, computed at 7 bits (0..99).
//    If value<=MAX_VALUE: address<=value[ADDR_W-1:0] and addr_valid pulse.
//    Otherwise: error pulse, address unchanged. Either way -> EMPTY, digits zeroed.
//  - enter+digit_valid in the same cycle: enter is processed on the pre-existing
//    digits. The digit is dropped and error pulses, possibly coincident with addr_valid.
//  - Latency: address/addr_valid/error update on the first rising edge after the strobe.
//    Pulses last exactly one cycle. Strobes held high act once per cycle.
//  - reset asserted mid-entry: held digits are lost and outputs take reset values immediately.
//    No pulse is generated on reset release.
// CONFIGURATION
//  TWODIGIT_ENTRY_AUTO_COMMIT_EN defined: accepting a second digit (ONE->TWO) also
//    performs the enter action in that same cycle, using the new digits. Range rules
//    apply unchanged. The FSM returns to EMPTY, so TWO is never held.
//    An explicit enter still commits a single held digit.
//  Undefined: commit happens only on enter, as described above.
// TESTING
//  1. Assert reset mid-cycle -> address=0, addr_valid=0, error=0, count=0 with no clock edge.
//  2. Digits 4,2 then enter -> next cycle address=42 (6'h2A), addr_valid high 1 cycle,
//     count=0.
//  3. ADDR_W=6: digits 7,1 then enter -> error pulse, addr_valid=0, address stays 42.
//  4. Digit 5 then enter -> address=5. Then enter with count=0 -> error pulse,
//     address stays 5. Then digit_in=4'hC -> error pulse, count stays 0.
//  5. Digits 1,2,3 -> third digit gives error, tens=1, ones=2. Then clear+enter in the
//     same cycle -> count=0, no pulses.
//  6. With TWODIGIT_ENTRY_AUTO_COMMIT_EN: digits 6,3 -> address=63 and addr_valid on the
//     edge after the second digit, with no enter. Digits 6,4 -> error pulse.

Source files
------------

// File: rtl/twodigit_entry_if.sv
// Front-panel digit entry bus: strobes from the panel logic, committed address and
// display echo back from the entry block.
interface twodigit_entry_if #(
  parameter int unsigned ADDR_W = 6
);
  logic [3:0]        digit_in;
  logic              digit_valid;
  logic              enter;
  logic              clear;
  logic [ADDR_W-1:0] address;
  logic              addr_valid;
  logic              error;
  logic [3:0]        tens_bcd;
  logic [3:0]        ones_bcd;
  logic [1:0]        count;

  modport master (
    output digit_in, digit_valid, enter, clear,
    input  address, addr_valid, error, tens_bcd, ones_bcd, count
  );

  modport slave (
    input  digit_in, digit_valid, enter, clear,
    output address, addr_valid, error, tens_bcd, ones_bcd, count
  );
endinterface

// File: rtl/twodigit_entry.sv
// Two-digit BCD entry: collects up to two decimal digits, commits tens*10+ones as a
// binary address with a one-cycle valid pulse. Rejected events pulse error.
// Optional: define TWODIGIT_ENTRY_AUTO_COMMIT_EN to commit as soon as the second
// digit is accepted.
module twodigit_entry #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned MAX_VALUE = (1 << ADDR_W) - 1
) (
  input logic              clock,
  input logic              reset,
  twodigit_entry_if.slave  bus
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_t;

  state_t            r_state;
  logic [3:0]        r_tens;
  logic [3:0]        r_ones;
  logic [ADDR_W-1:0] r_address;
  logic              r_addr_valid;
  logic              r_error;

  logic [6:0] w_value;      // held digits as binary, 0..99
  logic [6:0] w_new_value;  // value once digit_in is shifted in behind the held ones digit
  logic       w_digit_ok;
  logic       w_value_ok;
  logic       w_new_ok;

  // Binary values and range checks for the held and the prospective digit pair
  always_comb begin
    w_value     = 7'(r_tens) * 7'd10 + 7'(r_ones);
    w_new_value = 7'(r_ones) * 7'd10 + 7'(bus.digit_in);
    w_digit_ok  = (bus.digit_in <= 4'd9);
    w_value_ok  = (32'(w_value) <= MAX_VALUE);
    w_new_ok    = (32'(w_new_value) <= MAX_VALUE);
  end

  // Entry FSM with registered address, pulses and digit echo; clear > enter > digit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= StEmpty;
      r_tens       <= 4'd0;
      r_ones       <= 4'd0;
      r_address    <= '0;
      r_addr_valid <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_addr_valid <= 1'b0;
      r_error      <= 1'b0;
      if (bus.clear) begin
        r_state <= StEmpty;
        r_tens  <= 4'd0;
        r_ones  <= 4'd0;
      end else if (bus.enter) begin
        // A digit arriving with enter is dropped and flagged
        if (bus.digit_valid) begin
          r_error <= 1'b1;
        end
        if (r_state == StEmpty) begin
          r_error <= 1'b1;
        end else begin
          if (w_value_ok) begin
            r_address    <= w_value[ADDR_W-1:0];
            r_addr_valid <= 1'b1;
          end else begin
            r_error <= 1'b1;
          end
          r_state <= StEmpty;
          r_tens  <= 4'd0;
          r_ones  <= 4'd0;
        end
      end else if (bus.digit_valid) begin
        if (!w_digit_ok) begin
          r_error <= 1'b1;
        end else begin
          case (r_state)
            StEmpty: begin
              r_ones  <= bus.digit_in;
              r_tens  <= 4'd0;
              r_state <= StOne;
            end
            StOne: begin
`ifdef TWODIGIT_ENTRY_AUTO_COMMIT_EN
              if (w_new_ok) begin
                r_address    <= w_new_value[ADDR_W-1:0];
                r_addr_valid <= 1'b1;
              end else begin
                r_error <= 1'b1;
              end
              r_tens  <= 4'd0;
              r_ones  <= 4'd0;
              r_state <= StEmpty;
`else
              r_tens  <= r_ones;
              r_ones  <= bus.digit_in;
              r_state <= StTwo;
`endif
            end
            default: begin
              r_error <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign bus.address    = r_address;
  assign bus.addr_valid = r_addr_valid;
  assign bus.error      = r_error;
  assign bus.tens_bcd   = r_tens;
  assign bus.ones_bcd   = r_ones;
  assign bus.count      = r_state;

  // w_new_ok is only consumed by the auto-commit build
  logic w_unused;
  assign w_unused = w_new_ok;

endmodule

// File: tb/tb_twodigit_entry.sv
// Self-checking bench for twodigit_entry: directed scenarios plus random strobes,
// compared against a digit-list reference model.
module tb_twodigit_entry;

  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned MAX_VALUE = 63;

  logic clock;
  logic reset;

  twodigit_entry_if #(.ADDR_W(ADDR_W)) bus ();

  twodigit_entry #(
    .ADDR_W    (ADDR_W),
    .MAX_VALUE (MAX_VALUE)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: list of held digits, most significant first
  int held[$];
  int m_addr;
  int m_av;
  int m_err;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    held.delete();
    m_addr = 0;
    m_av   = 0;
    m_err  = 0;
  endtask

  task automatic model_commit();
    int v;
    v = 0;
    foreach (held[i]) v = v * 10 + held[i];
    if (v <= int'(MAX_VALUE)) begin
      m_addr = v;
      m_av   = 1;
    end else begin
      m_err = 1;
    end
    held.delete();
  endtask

  task automatic model_step(input int d, input bit dv, input bit en, input bit cl);
    m_av  = 0;
    m_err = 0;
    if (cl) begin
      held.delete();
    end else if (en) begin
      if (dv) m_err = 1;
      if (held.size() == 0) m_err = 1;
      else model_commit();
    end else if (dv) begin
      if (d > 9) m_err = 1;
      else if (held.size() == 2) m_err = 1;
      else begin
        held.push_back(d);
`ifdef TWODIGIT_ENTRY_AUTO_COMMIT_EN
        if (held.size() == 2) model_commit();
`endif
      end
    end
  endtask

  task automatic compare_all(input string tag);
    int exp_tens;
    int exp_ones;
    exp_tens = (held.size() == 2) ? held[0] : 0;
    exp_ones = (held.size() >= 1) ? held[held.size()-1] : 0;
    check({tag, "_addr"},  int'(bus.address),    m_addr);
    check({tag, "_av"},    int'(bus.addr_valid), m_av);
    check({tag, "_err"},   int'(bus.error),      m_err);
    check({tag, "_count"}, int'(bus.count),      held.size());
    check({tag, "_tens"},  int'(bus.tens_bcd),   exp_tens);
    check({tag, "_ones"},  int'(bus.ones_bcd),   exp_ones);
  endtask

  // One clock of stimulus: drive, take the edge, update the model, sample 1 time unit later
  task automatic step(input string tag, input int d, input bit dv, input bit en, input bit cl);
    bus.digit_in    = 4'(d);
    bus.digit_valid = dv;
    bus.enter       = en;
    bus.clear       = cl;
    @(posedge clock);
    model_step(d, dv, en, cl);
    #1;
    bus.digit_valid = 1'b0;
    bus.enter       = 1'b0;
    bus.clear       = 1'b0;
    compare_all(tag);
  endtask

  task automatic digit(input string tag, input int d);
    step(tag, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic enter_strobe(input string tag);
    step(tag, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock edge
  task automatic mid_reset(input string tag);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    compare_all(tag);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.digit_in    = 4'd0;
    bus.digit_valid = 1'b0;
    bus.enter       = 1'b0;
    bus.clear       = 1'b0;
    model_reset();
    #12;
    compare_all("rst");
    reset = 1'b0;

    // 42 entry and commit
    digit("t2_d4", 4);
    digit("t2_d2", 2);
    enter_strobe("t2_ent");
`ifndef TWODIGIT_ENTRY_AUTO_COMMIT_EN
    check("t2_addr42", int'(bus.address), 42);
    check("t2_av_hi", int'(bus.addr_valid), 1);
`endif
    idle("t2_idle");

    // Out of range value 71
    digit("t3_d7", 7);
    digit("t3_d1", 1);
    enter_strobe("t3_ent");
    idle("t3_idle");

    // Single digit, enter on empty, illegal digit
    digit("t4_d5", 5);
    enter_strobe("t4_ent");
    enter_strobe("t4_ent_empty");
    digit("t4_hex", 12);
    idle("t4_idle");

    // Full register, then clear+enter together
    digit("t5_d1", 1);
    digit("t5_d2", 2);
    digit("t5_d3", 3);
    step("t5_clr_ent", 0, 1'b0, 1'b1, 1'b1);

    // Enter with a coincident digit; boundary values 63 and 64
    digit("t6_d9", 9);
    step("t6_ent_dig", 4, 1'b1, 1'b1, 1'b0);
    digit("t7_d6", 6);
    digit("t7_d3", 3);
    enter_strobe("t7_ent63");
    digit("t7_d6b", 6);
    digit("t7_d4", 4);
    enter_strobe("t7_ent64");
    digit("t8_d0", 0);
    enter_strobe("t8_ent0");

    // Mid-entry asynchronous reset
    digit("t9_d8", 8);
    mid_reset("t9_rst");
    idle("t9_idle");

    // Random strobes
    for (int i = 0; i < 600; i++) begin
      int d;
      bit dv, en, cl;
      d  = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      dv = ($urandom_range(0, 1) == 1);
      en = ($urandom_range(0, 4) == 0);
      cl = ($urandom_range(0, 11) == 0);
      step("rnd", d, dv, en, cl);
      if ($urandom_range(0, 49) == 0) mid_reset("rnd_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
